// File: rtl/motion_bbox_tracker_if.sv
// Pixel-stream / bounding-box bundle for motion_bbox_tracker.
//   Pixel side (source -> tracker): frame_start, pix_valid, pix_xpos, pix_ypos, pix_bin
//   Box side (tracker -> overlay): box_xmin/xmax/ymin/ymax, box_valid, box_update, box_pix_cnt
// master: pixel source / box consumer. slave: the tracker.
interface motion_bbox_tracker_if #(
    parameter int unsigned COORD_W = 12,
    parameter int unsigned CNT_W   = 20
);
    logic               frame_start;
    logic               pix_valid;
    logic [COORD_W-1:0] pix_xpos;
    logic [COORD_W-1:0] pix_ypos;
    logic               pix_bin;

    logic [COORD_W-1:0] box_xmin;
    logic [COORD_W-1:0] box_xmax;
    logic [COORD_W-1:0] box_ymin;
    logic [COORD_W-1:0] box_ymax;
    logic               box_valid;
    logic               box_update;
    logic [CNT_W-1:0]   box_pix_cnt;

    modport master (
        output frame_start, pix_valid, pix_xpos, pix_ypos, pix_bin,
        input  box_xmin, box_xmax, box_ymin, box_ymax, box_valid, box_update, box_pix_cnt
    );

    modport slave (
        input  frame_start, pix_valid, pix_xpos, pix_ypos, pix_bin,
        output box_xmin, box_xmax, box_ymin, box_ymax, box_valid, box_update, box_pix_cnt
    );
endinterface

// File: rtl/motion_bbox_tracker.sv
// Motion bounding-box tracker.
// Accumulates the bounding box of thresholded motion pixels over FRAME_ACC frames and
// publishes a registered box, a validity flag (>= MIN_PIX pixels) and a one-cycle update
// pulse at every window close.
// Ports:
//   clk        pixel clock
//   rst_n      asynchronous active-low reset
//   track_en_i tracking enable; low forces idle and clears box_valid
//   trk_io     slave side of motion_bbox_tracker_if (pixel stream in, box out)
module motion_bbox_tracker #(
    parameter int unsigned IMG_HDISP = 640,
    parameter int unsigned IMG_VDISP = 480,
    parameter int unsigned COORD_W   = 12,
    parameter int unsigned FRAME_ACC = 10,
    parameter int unsigned MIN_PIX   = 16,
    parameter int unsigned CNT_W     = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    track_en_i,
    motion_bbox_tracker_if.slave    trk_io
);

    localparam int unsigned FRM_W = (FRAME_ACC > 1) ? $clog2(FRAME_ACC) : 1;
    localparam logic [FRM_W-1:0]   FrmLast = FRM_W'(FRAME_ACC - 1);
    localparam logic [COORD_W-1:0] XSent   = COORD_W'(IMG_HDISP);
    localparam logic [COORD_W-1:0] YSent   = COORD_W'(IMG_VDISP);
    localparam logic [CNT_W-1:0]   CntMax  = '1;
    localparam logic [CNT_W-1:0]   MinCnt  = CNT_W'(MIN_PIX);

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    typedef struct packed {
        logic [COORD_W-1:0] xmin;
        logic [COORD_W-1:0] xmax;
        logic [COORD_W-1:0] ymin;
        logic [COORD_W-1:0] ymax;
        logic [CNT_W-1:0]   cnt;
    } acc_t;

    state_e             state_q, state_d;
    logic [FRM_W-1:0]   frm_q, frm_d;
    acc_t               acc_q, acc_d;
    acc_t               sent, base, mrg;

    logic [COORD_W-1:0] box_xmin_q, box_xmin_d;
    logic [COORD_W-1:0] box_xmax_q, box_xmax_d;
    logic [COORD_W-1:0] box_ymin_q, box_ymin_d;
    logic [COORD_W-1:0] box_ymax_q, box_ymax_d;
    logic               box_valid_q, box_valid_d;
    logic               box_update_q, box_update_d;
    logic [CNT_W-1:0]   box_pix_cnt_q, box_pix_cnt_d;

    logic               hit;
    logic               close;

    // Accumulator merge: the current pixel is folded into either the running accumulators
    // or fresh sentinels (window open / window close), so a hit on a frame_start cycle
    // always lands in the window that frame_start opens.
    always_comb begin
        sent      = '0;
        sent.xmin = XSent;
        sent.ymin = YSent;

        hit   = trk_io.pix_valid & trk_io.pix_bin &
                (trk_io.pix_xpos < XSent) & (trk_io.pix_ypos < YSent);
        close = (state_q == StAccum) && trk_io.frame_start && (frm_q == FrmLast);

        base = ((state_q == StIdle) || close) ? sent : acc_q;
        mrg  = base;
        if (hit) begin
            if (trk_io.pix_xpos < base.xmin) mrg.xmin = trk_io.pix_xpos;
            if (trk_io.pix_xpos > base.xmax) mrg.xmax = trk_io.pix_xpos;
            if (trk_io.pix_ypos < base.ymin) mrg.ymin = trk_io.pix_ypos;
            if (trk_io.pix_ypos > base.ymax) mrg.ymax = trk_io.pix_ypos;
            // Saturating count: a huge window must not wrap below MIN_PIX.
            if (base.cnt != CntMax) mrg.cnt = base.cnt + 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        frm_d         = frm_q;
        acc_d         = acc_q;
        box_xmin_d    = box_xmin_q;
        box_xmax_d    = box_xmax_q;
        box_ymin_d    = box_ymin_q;
        box_ymax_d    = box_ymax_q;
        box_valid_d   = box_valid_q;
        box_update_d  = 1'b0;
        box_pix_cnt_d = box_pix_cnt_q;

        if (!track_en_i) begin
            // Disable drops the window in progress; the last box coordinates stay visible.
            state_d     = StIdle;
            frm_d       = '0;
            acc_d       = sent;
            box_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    acc_d = sent;
                    if (trk_io.frame_start) begin
                        state_d = StAccum;
                        frm_d   = '0;
                        acc_d   = mrg;
                    end
                end
                StAccum: begin
                    acc_d = mrg;
                    if (close) begin
                        frm_d         = '0;
                        box_update_d  = 1'b1;
                        box_pix_cnt_d = acc_q.cnt;
                        if (acc_q.cnt >= MinCnt) begin
                            box_xmin_d  = acc_q.xmin;
                            box_xmax_d  = acc_q.xmax;
                            box_ymin_d  = acc_q.ymin;
                            box_ymax_d  = acc_q.ymax;
                            box_valid_d = 1'b1;
                        end else begin
                            box_valid_d = 1'b0;
                        end
                    end else if (trk_io.frame_start) begin
                        frm_d = frm_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            frm_q         <= '0;
            acc_q         <= '{xmin: XSent, xmax: '0, ymin: YSent, ymax: '0, cnt: '0};
            box_xmin_q    <= '0;
            box_xmax_q    <= '0;
            box_ymin_q    <= '0;
            box_ymax_q    <= '0;
            box_valid_q   <= 1'b0;
            box_update_q  <= 1'b0;
            box_pix_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            frm_q         <= frm_d;
            acc_q         <= acc_d;
            box_xmin_q    <= box_xmin_d;
            box_xmax_q    <= box_xmax_d;
            box_ymin_q    <= box_ymin_d;
            box_ymax_q    <= box_ymax_d;
            box_valid_q   <= box_valid_d;
            box_update_q  <= box_update_d;
            box_pix_cnt_q <= box_pix_cnt_d;
        end
    end

    assign trk_io.box_xmin    = box_xmin_q;
    assign trk_io.box_xmax    = box_xmax_q;
    assign trk_io.box_ymin    = box_ymin_q;
    assign trk_io.box_ymax    = box_ymax_q;
    assign trk_io.box_valid   = box_valid_q;
    assign trk_io.box_update  = box_update_q;
    assign trk_io.box_pix_cnt = box_pix_cnt_q;

endmodule

// File: tb/tb_motion_bbox_tracker.sv
// Directed bench for motion_bbox_tracker: 16x8 image, 2-frame windows, MIN_PIX=4.
// Frames are short synthetic bursts; only frame_start pulses delimit them.
module tb_motion_bbox_tracker;

    localparam int unsigned CW = 12;
    localparam int unsigned NW = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic track_en = 1'b1;

    int total = 0;
    int bad = 0;
    int upd_cnt = 0;

    always #5 clk = ~clk;

    motion_bbox_tracker_if #(.COORD_W(CW), .CNT_W(NW)) trk_if ();

    motion_bbox_tracker #(
        .IMG_HDISP (16),
        .IMG_VDISP (8),
        .COORD_W   (CW),
        .FRAME_ACC (2),
        .MIN_PIX   (4),
        .CNT_W     (NW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .track_en_i (track_en),
        .trk_io     (trk_if.slave)
    );

    always @(negedge clk) begin
        if (trk_if.box_update === 1'b1) upd_cnt <= upd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; inputs return to quiet afterwards.
    task automatic step(input logic fs, input logic v, input int x, input int y, input logic b);
        trk_if.frame_start = fs;
        trk_if.pix_valid   = v;
        trk_if.pix_xpos    = CW'(x);
        trk_if.pix_ypos    = CW'(y);
        trk_if.pix_bin     = b;
        @(posedge clk);
        #1;
        trk_if.frame_start = 1'b0;
        trk_if.pix_valid   = 1'b0;
        trk_if.pix_bin     = 1'b0;
    endtask

    task automatic hit(input int x, input int y);
        step(1'b0, 1'b1, x, y, 1'b1);
    endtask

    task automatic fs();
        step(1'b1, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic chk_box(input string tag, input int x0, input int x1, input int y0,
                           input int y1, input int v, input int c);
        chk({tag, "_xmin"}, 32'(trk_if.box_xmin), x0);
        chk({tag, "_xmax"}, 32'(trk_if.box_xmax), x1);
        chk({tag, "_ymin"}, 32'(trk_if.box_ymin), y0);
        chk({tag, "_ymax"}, 32'(trk_if.box_ymax), y1);
        chk({tag, "_valid"}, 32'(trk_if.box_valid), v);
        chk({tag, "_cnt"}, 32'(trk_if.box_pix_cnt), c);
    endtask

    initial begin
        trk_if.frame_start = 1'b0;
        trk_if.pix_valid   = 1'b0;
        trk_if.pix_xpos    = '0;
        trk_if.pix_ypos    = '0;
        trk_if.pix_bin     = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_box("rst", 0, 0, 0, 0, 0, 0);
        chk("rst_upd", 32'(trk_if.box_update), 0);
        rst_n = 1'b1;
        idle(2);

        // Three empty frames: one update after frame 2
        fs(); idle(3);
        fs(); idle(3);
        chk("empty_no_upd_yet", 32'(upd_cnt), 0);
        fs();
        chk("empty_upd", 32'(trk_if.box_update), 1);
        chk_box("empty", 0, 0, 0, 0, 0, 0);
        idle(1);
        chk("empty_upd_drop", 32'(trk_if.box_update), 0);
        chk("empty_upd_cnt", 32'(upd_cnt), 1);

        // Four hits plus out-of-range and unqualified pixels
        hit(3, 2); hit(10, 5);
        hit(20, 1); hit(2, 9);
        step(1'b0, 1'b0, 1, 1, 1'b1);
        fs();
        hit(7, 1); hit(4, 6);
        fs();
        chk("w2_upd", 32'(trk_if.box_update), 1);
        chk_box("w2", 3, 10, 1, 6, 1, 4);
        idle(1);
        chk("w2_upd_drop", 32'(trk_if.box_update), 0);

        // Three hits; closing frame_start carries a hit at (0,0) for the next window
        hit(5, 3); hit(6, 4);
        fs();
        hit(8, 2);
        step(1'b1, 1'b1, 0, 0, 1'b1);
        chk("w3_upd", 32'(trk_if.box_update), 1);
        chk_box("w3", 3, 10, 1, 6, 0, 3);

        hit(9, 7); hit(2, 3);
        fs();
        hit(12, 4);
        fs();
        chk("w4_upd", 32'(trk_if.box_update), 1);
        chk_box("w4", 0, 12, 0, 7, 1, 4);

        // Mid-window disable for one cycle, re-enabled mid-frame
        hit(5, 5);
        track_en = 1'b0;
        hit(6, 6);
        track_en = 1'b1;
        chk("dis_upd", 32'(trk_if.box_update), 0);
        chk_box("dis", 0, 12, 0, 7, 0, 4);
        hit(1, 1); idle(2);
        fs();
        hit(6, 2); hit(7, 3);
        fs();
        chk("w5_mid_upd", 32'(trk_if.box_update), 0);
        chk("w5_mid_valid", 32'(trk_if.box_valid), 0);
        hit(8, 4); hit(9, 5);
        fs();
        chk("w5_upd", 32'(trk_if.box_update), 1);
        chk_box("w5", 6, 9, 2, 5, 1, 4);
        idle(2);
        chk("total_upd_cnt", 32'(upd_cnt), 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/motion_bbox_tracker.md
Name: motion_bbox_tracker

Overview:
- Consumes the thresholded frame-difference pixel stream in the LCD pixel clock domain, together with the LCD x/y coordinates.
- Accumulates the bounding box of all active (motion) pixels over a window of FRAME_ACC frames.
- Publishes a registered box plus a validity flag once per window; the overlay stage draws the red rectangle from these outputs.
- Replaces the ad-hoc min/max/frame-count logic with a self-contained, verifiable stage. Adds a minimum-pixel-count gate to suppress noise boxes.

Parameters:
- IMG_HDISP, 640, active pixels per line; x coordinates >= IMG_HDISP are ignored.
- IMG_VDISP, 480, active lines per frame; y coordinates >= IMG_VDISP are ignored.
- COORD_W, 12, coordinate width.
- FRAME_ACC, 10, frames per accumulation window (>=1).
- MIN_PIX, 16, minimum active-pixel count in a window for box_valid=1.
- CNT_W, 20, active-pixel counter width.

Ports:
- clk  in  1  pixel clock (clk_vga domain).
- rst_n  in  1  asynchronous active-low reset.
- track_en  in  1  tracking enable; low forces IDLE.
- frame_start  in  1  one-cycle pulse coincident with the first pixel (x=0,y=0) of each frame.
- pix_valid  in  1  pixel qualifier (LCD data request).
- pix_xpos  in  COORD_W  pixel x coordinate.
- pix_ypos  in  COORD_W  pixel y coordinate.
- pix_bin  in  1  thresholded motion pixel (1 = motion).
- box_xmin, box_xmax, box_ymin, box_ymax  out  COORD_W each  latched bounding box.
- box_valid  out  1  latched box holds >= MIN_PIX pixels.
- box_update  out  1  one-cycle pulse when outputs are refreshed.
- box_pix_cnt  out  CNT_W  active-pixel count of the last window.

Behaviour:
- Reset values: all box_* coordinates 0, box_valid 0, box_update 0, box_pix_cnt 0, state IDLE, frm_cnt 0.
- Accumulator sentinels: acc_xmin=IMG_HDISP, acc_xmax=0, acc_ymin=IMG_VDISP, acc_ymax=0, acc_cnt=0.
- Hit: pix_valid & pix_bin & pix_xpos<IMG_HDISP & pix_ypos<IMG_VDISP.
- A hit updates acc_xmin=min, acc_xmax=max, acc_ymin=min, acc_ymax=max, and acc_cnt+1.
- acc_cnt saturates at 2^CNT_W-1; it never wraps.
- IDLE:
  - Accumulators held at sentinels; hits ignored.
  - Partial frames after reset or after enable are discarded.
  - frame_start & track_en -> ACCUM with frm_cnt=0. The pixel in that same cycle is accumulated.
- ACCUM:
  - Hits accumulate every cycle.
  - frame_start with frm_cnt<FRAME_ACC-1 -> frm_cnt+1; accumulation continues.
  - frame_start with frm_cnt==FRAME_ACC-1 closes the window:
    - Same edge: outputs latch from the pre-update accumulators. Visible the cycle after frame_start.
    - box_update=1 for exactly that one cycle.
    - box_pix_cnt = acc_cnt.
    - If acc_cnt>=MIN_PIX: box_* = acc_*, box_valid=1. Otherwise box_valid=0 and box_* hold their previous values.
    - Accumulators reload to sentinels merged with the current cycle's pixel, i.e. a hit on the closing frame_start cycle belongs to the new window. frm_cnt=0.
- track_en low (any state, mid-window included):
  - Next cycle: state IDLE, accumulators to sentinels, frm_cnt 0, box_valid 0, no box_update.
  - box_* coordinates and box_pix_cnt hold.
- Single hit pixel gives xmin==xmax and ymin==ymax; this is legal.
- Out-of-range coordinates with pix_bin=1 never affect the accumulators.
- frame_start with pix_valid=0 is still honoured.
- Pixel latency: a hit in the last frame of a window appears on the outputs one cycle after the closing frame_start.
- No backpressure; input is accepted every cycle.

Test Plan:
- Common setup: IMG_HDISP=16, IMG_VDISP=8, FRAME_ACC=2, MIN_PIX=4.
- Reset then 3 frames with no hits -> box_update pulses once (after frame 2), box_valid=0, box_pix_cnt=0, coords 0.
- Frames 1-2 with hits at (3,2),(10,5),(7,1),(4,6) -> one cycle after 3rd frame_start: box=(3,10,1,6), box_valid=1, box_pix_cnt=4, box_update high 1 cycle.
- Only 3 hits in next window -> box_valid=0, box_pix_cnt=3, coords hold (3,10,1,6).
- Hit on the closing frame_start cycle at (0,0) -> excluded from the closed window, included in the next (next xmin=0, ymin=0).
- pix_bin=1 at x=20 or y=9 -> no effect on box or count.
- Mid-window track_en=0 for 1 cycle, re-enabled mid-frame -> box_valid=0, hits ignored until next frame_start; next update occurs 2 frames after that frame_start.
